// File: rtl/alu_mc.sv
// alu_mc: registered valid/ready ALU with single-cycle ops and an iterative shift-add multiplier
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z_flag,
    output logic             busy
);
    localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
    logic [0:0]         state;
    logic [SW:0]        cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_nx;
    logic [WIDTH-1:0]   mplier, res, mres;
    logic [SW-1:0]      shamt;
    logic               hi, accept, is_mul, done;

    assign shamt    = in2[SW-1:0];
    assign in_ready = state == IDLE && (!out_valid || out_ready);
    assign busy     = state == BUSY;
    assign accept   = in_valid && in_ready;
    assign is_mul   = func[3:1] == 3'b100;
    assign acc_nx   = acc + (mplier[0] ? mcand : '0);
    assign mres     = hi ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
    // The last partial product is folded in on the same edge the result loads.
    assign done     = state == BUSY && cnt == (SW+1)'(1);

    always_comb begin
        res = '0;
        case (func)
            4'b0010: res = in1 + in2;
            4'b0101: res = in1 - in2;
            4'b0000: res = in1 << shamt;
            4'b0011: res = in1 >> shamt;
            4'b0100: res = $signed(in1) >>> shamt;
            4'b0001: res = in1 | in2;
            4'b0110: res = in1 & in2;
            4'b0111: res = in1 ^ in2;
            4'b1010: res = WIDTH'($signed(in1) < $signed(in2));
            4'b1011: res = WIDTH'(in1 < in2);
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            hi        <= 1'b0;
            out       <= '0;
            z_flag    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (accept && is_mul) begin
                    state  <= BUSY;
                    cnt    <= (SW+1)'(WIDTH);
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, in1};
                    mplier <= in2;
                    hi     <= func[0];
                end
            end else begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - (SW+1)'(1);
                if (done) state <= IDLE;
            end
            if (done) begin
                out       <= mres;
                z_flag    <= mres == '0;
                out_valid <= 1'b1;
            end else if (accept && !is_mul) begin
                out       <= res;
                z_flag    <= res == '0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc at WIDTH=32 and WIDTH=8
module tb_alu_mc;
    localparam logic [3:0] SLL = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SRL = 4'b0011,
                           SRA = 4'b0100, SUB = 4'b0101, AND_ = 4'b0110, XOR_ = 4'b0111,
                           MUL = 4'b1000, MULHU = 4'b1001, SLT = 4'b1010, SLTU = 4'b1011;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, out_ready = 1, in_ready, out_valid, z_flag, busy;
    logic [31:0] in1 = 0, in2 = 0, out;
    logic [3:0] func = 0;
    logic in_valid8 = 0, out_ready8 = 1, in_ready8, out_valid8, z_flag8, busy8;
    logic [7:0] in1_8 = 0, in2_8 = 0, out8;
    logic [3:0] func8 = 0;
    int errors = 0, checks = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .func(func), .out_valid(out_valid), .out_ready(out_ready), .out(out), .z_flag(z_flag), .busy(busy)
    );
    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in1(in1_8), .in2(in2_8),
        .func(func8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .z_flag(z_flag8), .busy(busy8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; func = ADD; in1 = 7; in2 = 5; in_valid8 = 1; func8 = ADD;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset out: got %h want 0", out); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL reset z_flag: got %b want 0", z_flag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset out_valid8: got %b want 0", out_valid8); end
        in_valid = 0; in_valid8 = 0; rst_n = 1;
        step();
    endtask

    task automatic test_single();
        logic [3:0] f [12];
        logic [31:0] a [12], b [12], e [12];
        f = '{ADD, SUB, SRA, SLT, SLTU, SLL, SRL, OR_, AND_, XOR_, ADD, SRA};
        a = '{32'd7, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000000,
              32'hF0F0, 32'hF0F0, 32'hFFFF, 32'hFFFFFFFF, 32'h40000000};
        b = '{32'd5, 32'd7, 32'd33, 32'd1, 32'd1, 32'd31, 32'd36, 32'h0F00, 32'h0FF0, 32'h00FF, 32'd1, 32'd1};
        e = '{32'd12, 32'hFFFFFFFE, 32'hC0000000, 32'd1, 32'd0, 32'h80000000, 32'h08000000,
              32'hFFF0, 32'h00F0, 32'hFF00, 32'd0, 32'h20000000};
        for (int i = 0; i < 12; i++) begin
            func = f[i]; in1 = a[i]; in2 = b[i]; in_valid = 1;
            step();
            checks++;
            if ({out_valid, z_flag, out} !== {1'b1, e[i] == 32'd0, e[i]}) begin
                errors++;
                $display("FAIL single op%0d func=%b: got valid=%b z=%b out=%h want valid=1 z=%b out=%h",
                         i, f[i], out_valid, z_flag, out, e[i] == 32'd0, e[i]);
            end
        end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single drain: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            func = ADD; in1 = 32'(i) + 32'd10; in2 = 32'(i); in_valid = 1;
            step();
            checks++;
            if ({out_valid, out} !== {1'b1, 32'(2 * i + 10)}) begin
                errors++; $display("FAIL stream %0d: got valid=%b out=%h want valid=1 out=%h", i, out_valid, out, 32'(2 * i + 10));
            end
        end
        out_ready = 0; in1 = 100; in2 = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready: got %b want 0", in_ready); end
        repeat (3) begin
            step();
            checks++;
            if ({out_valid, in_ready, out} !== {1'b1, 1'b0, 32'd16}) begin
                errors++; $display("FAIL stall hold: got valid=%b in_ready=%b out=%h want 1 0 00000010", out_valid, in_ready, out);
            end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 0;
        checks++; if ({out_valid, out} !== {1'b1, 32'd101}) begin errors++; $display("FAIL pending op: got valid=%b out=%h want 1 00000065", out_valid, out); end
        step();
    endtask

    task automatic run_mul32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int bad = 0;
        func = f; in1 = a; in2 = b; in_valid = 1;
        step();
        in_valid = 0; in1 = 32'h5A5A5A5A; in2 = 32'hA5A5A5A5; func = ADD;
        for (int k = 0; k < 32; k++) begin
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mul busy window func=%b: got %0d bad cycles want 0", f, bad); end
        checks++;
        if ({out_valid, busy, z_flag, out} !== {1'b1, 1'b0, e == 32'd0, e}) begin
            errors++;
            $display("FAIL mul result func=%b a=%h b=%h: got valid=%b busy=%b z=%b out=%h want 1 0 %b %h",
                     f, a, b, out_valid, busy, z_flag, out, e == 32'd0, e);
        end
    endtask

    task automatic test_mul();
        run_mul32(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_mul32(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_mul32(MUL, 32'h0, 32'h1234, 32'h0);
        run_mul32(MUL, 32'h3039, 32'h3E8, 32'h00BC5EA8);
        run_mul32(MULHU, 32'h10000, 32'h10001, 32'h1);
        step();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        func = MUL; in1 = 7; in2 = 9; in_valid = 1;
        step();
        in_valid = 0;
        repeat (10) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid-mul busy: got %b want 1", busy); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({out_valid, busy, z_flag, in_ready, out} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL async reset: got valid=%b busy=%b z=%b in_ready=%b out=%h want 0 0 0 1 0", out_valid, busy, z_flag, in_ready, out);
        end
        step(); step();
        rst_n = 1;
        func = ADD; in1 = 1; in2 = 1; in_valid = 1;
        step();
        in_valid = 0;
        checks++; if ({out_valid, z_flag, out} !== {1'b1, 1'b0, 32'd2}) begin errors++; $display("FAIL post-reset add: got valid=%b z=%b out=%h want 1 0 2", out_valid, z_flag, out); end
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stale mul result: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reserved();
        func = 4'b1110; in1 = 5; in2 = 3; in_valid = 1;
        step();
        checks++; if ({out_valid, z_flag, out} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL reserved 1110: got valid=%b z=%b out=%h want 1 1 0", out_valid, z_flag, out); end
        func = ADD; in1 = 3; in2 = 4;
        step();
        func = 4'b1111; in1 = 9; in2 = 9;
        step();
        in_valid = 0;
        checks++; if ({out_valid, z_flag, out} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL reserved 1111: got valid=%b z=%b out=%h want 1 1 0", out_valid, z_flag, out); end
        step();
    endtask

    task automatic run_mul8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        int bad = 0;
        func8 = f; in1_8 = a; in2_8 = b; in_valid8 = 1;
        step();
        in_valid8 = 0; in1_8 = 8'hA5; in2_8 = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            if (busy8 !== 1'b1 || out_valid8 !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL w8 busy window func=%b: got %0d bad cycles want 0", f, bad); end
        checks++;
        if ({out_valid8, z_flag8, out8} !== {1'b1, e == 8'd0, e}) begin
            errors++; $display("FAIL w8 mul func=%b: got valid=%b z=%b out=%h want 1 %b %h", f, out_valid8, z_flag8, out8, e == 8'd0, e);
        end
    endtask

    task automatic test_w8();
        func8 = ADD; in1_8 = 8'hFF; in2_8 = 8'h02; in_valid8 = 1;
        step();
        checks++; if ({out_valid8, out8} !== {1'b1, 8'h01}) begin errors++; $display("FAIL w8 add: got valid=%b out=%h want 1 01", out_valid8, out8); end
        func8 = SRA; in1_8 = 8'h80; in2_8 = 8'd9;
        step();
        in_valid8 = 0;
        checks++; if ({out_valid8, out8} !== {1'b1, 8'hC0}) begin errors++; $display("FAIL w8 sra: got valid=%b out=%h want 1 c0", out_valid8, out8); end
        run_mul8(MUL, 8'h10, 8'h10, 8'h00);
        run_mul8(MULHU, 8'h10, 8'h10, 8'h01);
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_reset_mid();
        test_reserved();
        test_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
